// File: rtl/float_to_int.sv
// IEEE-754 single-precision to 32-bit signed integer converter.
// Truncates toward zero, saturates on overflow, and shifts at most SHIFT_STEP bits per cycle.
module float_to_int #(
    parameter int SHIFT_STEP = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] in_float,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_int,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_overflow,
    output logic        out_invalid,
    output logic        out_inexact
);

    typedef enum logic [1:0] {IDLE, SHIFT, NEG, HOLD} state_t;

    state_t      state_reg, state_next;
    logic [31:0] mag_reg, mag_next;
    logic [4:0]  rem_reg, rem_next;
    logic        dir_left_reg, dir_left_next;
    logic        sticky_reg, sticky_next;
    logic        sign_reg, sign_next;
    logic [31:0] out_int_reg, out_int_next;
    logic        ovf_reg, ovf_next;
    logic        inv_reg, inv_next;
    logic        inx_reg, inx_next;
    logic        out_valid_reg, out_valid_next;

    logic        in_sign;
    logic [7:0]  in_exp;
    logic [22:0] in_frac;
    logic [31:0] sat_val;
    logic [7:0]  exp_diff;
    logic [4:0]  step_n;
    logic [31:0] lost_mask;

    assign in_sign  = in_float[31];
    assign in_exp   = in_float[30:23];
    assign in_frac  = in_float[22:0];
    assign sat_val  = in_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    assign exp_diff = (in_exp > 8'd150) ? (in_exp - 8'd150) : (8'd150 - in_exp);
    assign step_n   = (int'(rem_reg) < SHIFT_STEP) ? rem_reg : 5'(SHIFT_STEP);

    // Bits that fall off the bottom during a right shift of step_n positions
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_lost
            assign lost_mask[gi] = (5'(gi) < step_n);
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        mag_next       = mag_reg;
        rem_next       = rem_reg;
        dir_left_next  = dir_left_reg;
        sticky_next    = sticky_reg;
        sign_next      = sign_reg;
        out_int_next   = out_int_reg;
        ovf_next       = ovf_reg;
        inv_next       = inv_reg;
        inx_next       = inx_reg;
        out_valid_next = out_valid_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    sign_next   = in_sign;
                    sticky_next = 1'b0;
                    if (in_exp == 8'd255 || in_exp < 8'd127 || in_exp >= 8'd158) begin
                        state_next     = HOLD;
                        out_valid_next = 1'b1;
                        ovf_next       = 1'b0;
                        inv_next       = 1'b0;
                        inx_next       = 1'b0;
                        if (in_exp == 8'd255 && in_frac != 23'd0) begin
                            out_int_next = 32'd0;
                            inv_next     = 1'b1;
                        end else if (in_exp < 8'd127) begin
                            out_int_next = 32'd0;
                            inx_next     = (in_exp != 8'd0) || (in_frac != 23'd0);
                        end else if (in_sign && in_exp == 8'd158 && in_frac == 23'd0) begin
                            // -2^31 is exactly representable
                            out_int_next = 32'h8000_0000;
                        end else begin
                            out_int_next = sat_val;
                            ovf_next     = 1'b1;
                        end
                    end else begin
                        mag_next      = {8'b0, 1'b1, in_frac};
                        dir_left_next = (in_exp > 8'd150);
                        rem_next      = exp_diff[4:0];
                        state_next    = (exp_diff == 8'd0) ? NEG : SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (dir_left_reg) begin
                    mag_next = mag_reg << step_n;
                end else begin
                    mag_next = mag_reg >> step_n;
                    if ((mag_reg & lost_mask) != 32'd0) sticky_next = 1'b1;
                end
                rem_next = rem_reg - step_n;
                if (rem_reg == step_n) state_next = NEG;
            end
            NEG: begin
                out_int_next   = sign_reg ? (~mag_reg + 32'd1) : mag_reg;
                ovf_next       = 1'b0;
                inv_next       = 1'b0;
                inx_next       = sticky_reg;
                out_valid_next = 1'b1;
                state_next     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            mag_reg       <= 32'd0;
            rem_reg       <= 5'd0;
            dir_left_reg  <= 1'b0;
            sticky_reg    <= 1'b0;
            sign_reg      <= 1'b0;
            out_int_reg   <= 32'd0;
            ovf_reg       <= 1'b0;
            inv_reg       <= 1'b0;
            inx_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mag_reg       <= mag_next;
            rem_reg       <= rem_next;
            dir_left_reg  <= dir_left_next;
            sticky_reg    <= sticky_next;
            sign_reg      <= sign_next;
            out_int_reg   <= out_int_next;
            ovf_reg       <= ovf_next;
            inv_reg       <= inv_next;
            inx_reg       <= inx_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign in_ready     = (state_reg == IDLE);
    assign out_int      = out_int_reg;
    assign out_valid    = out_valid_reg;
    assign out_overflow = ovf_reg;
    assign out_invalid  = inv_reg;
    assign out_inexact  = inx_reg;

endmodule

// File: doc/float_to_int.md
Name: float_to_int

Overview:
- Iterative IEEE-754 single-precision to 32-bit signed integer converter. Conversion truncates toward zero and saturates on overflow.
- Sits directly downstream of the floating-point add/subtract stage and consumes its 32-bit result word.
- Valid/ready handshake on both sides. One multi-cycle shifter, so a SHIFT_STEP-bit barrel shift is used per cycle instead of a full 32-bit one.

Parameters:
- SHIFT_STEP, 4, maximum bits shifted per SHIFT cycle. Legal range 1..31.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_float  input  32  IEEE single {sign[31], exp[30:23], frac[22:0]}.
- in_valid  input  1  in_float is valid.
- in_ready  output  1  block can accept; high only in IDLE.
- out_int  output  32  two's-complement result; registered.
- out_valid  output  1  out_int and flags are valid.
- out_ready  input  1  consumer accepts the result.
- out_overflow  output  1  result saturated (includes ±inf).
- out_invalid  output  1  input was NaN.
- out_inexact  output  1  nonzero fraction bits were discarded.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - out_valid, out_int, and all three flags = 0.
  - Internal shift register and remaining-count are cleared.
  - Reset mid-conversion aborts the conversion with no output.
- States: IDLE, SHIFT, NEG, HOLD.
- in_ready = (state==IDLE). Accept happens when in_valid && in_ready at a rising edge. in_float is sampled only at accept.
- Classification at accept, with e=exp, f=frac:
  - e==255, f!=0: NaN → out_int=0, invalid=1 → HOLD.
  - e==255, f==0: inf → out_int = sign ? 0x80000000 : 0x7FFFFFFF, overflow=1 → HOLD.
  - e<127 (includes zero and denormals, which are treated as zero): out_int=0. inexact = (e!=0 || f!=0) → HOLD.
  - e>=158: if sign=1, e==158 and f==0 → out_int=0x80000000, no flags. Otherwise saturate by sign, overflow=1. Either way → HOLD.
  - Otherwise, normal path:
    - mag = {8'b0, 1'b1, f}.
    - s = e-150, signed, range -23..+7.
    - rem = |s|, dir = left if s>0.
    - Next state is SHIFT if rem!=0, else NEG.
- SHIFT, each cycle:
  - n = min(rem, SHIFT_STEP).
  - Shift mag by n in direction dir; rem -= n.
  - Right shifts OR every bit shifted out into a sticky bit.
  - When rem becomes 0 → NEG.
- NEG, one cycle:
  - out_int = sign ? (~mag)+1 : mag.
  - inexact = sticky.
  - → HOLD.
- Transitions into HOLD set out_valid=1 on the same edge.
- HOLD:
  - out_int and flags are held stable.
  - On out_ready=1 at an edge: out_valid→0, state→IDLE. Output registers keep their last value.
  - No accept in the same cycle as the HOLD→IDLE transition (in_ready is 0 during HOLD).
- Latency, edges from accept to out_valid=1:
  - special cases: 1.
  - normal: 2 + ceil(|s|/SHIFT_STEP).
- Throughput: one conversion per latency+1 cycles minimum. in_ready returns to 1 the cycle after the result is taken.
- Flags are mutually exclusive except that inexact can only accompany normal-path or e<127 results.
- out_ready asserted while not in HOLD has no effect. in_valid outside IDLE is ignored and must be held by the producer.

Test Plan:
- Reset during SHIFT, SHIFT_STEP=4: accept 0x3F800000, pulse reset_n low at the 3rd edge → out_valid=0, in_ready=1, out_int=0 after release; no stale result appears.
- Normal right shifts, SHIFT_STEP=4, out_ready=1 on out_valid:
  - 0x3F800000 (1.0) → out_int=1, no flags, out_valid 8 edges after accept.
  - 0x42C90000 (100.5) → 100, inexact=1.
  - 0xC0700000 (-3.75) → 0xFFFFFFFD, inexact=1.
- Left shift: 0x4C800000 (2^26, s=+3) → 0x04000000, no flags, latency 3.
- Boundaries:
  - 0x4F000000 → 0x7FFFFFFF, overflow=1.
  - 0xCF000000 → 0x80000000, no flags.
  - 0xCF000001 → 0x80000000, overflow=1.
  - Each has latency 1.
- Specials:
  - 0x7FC00000 → 0, invalid=1.
  - 0xFF800000 → 0x80000000, overflow=1.
  - 0x3F000000 (0.5) → 0, inexact=1.
  - 0x00000000 → 0, no flags.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD → out_int and flags stable, in_ready=0, a new in_valid is not accepted. Raise out_ready → next cycle in_ready=1 and the queued input is accepted.
